// File: rtl/imem_if.sv
// imem_if: fetch request/response and program-load signals between a core and imem_responder.
interface imem_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_inst;
    logic                  resp_err;
    logic                  load_en;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [31:0]           load_data;

    modport master (
        output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction memory answering one fetch at a time with optional wait states.
// Define IMEM_WAIT_STATE_EN to compile in the WAIT state and its WAIT_CYCLES down-counter.
module imem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    imem_if.slave bus,
    output logic busy
);
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IMEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    state_t      state, state_n;
    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] src, inst_n;
    logic        err_n, cap, accept;

`ifdef IMEM_WAIT_STATE_EN
    logic [3:0]  cnt, cnt_n;
    logic [31:0] addr;
    // The word is captured on RESP entry, which is either the accept edge or the last WAIT edge.
    assign src = (state == IDLE) ? bus.req_addr : addr;
`else
    assign src = bus.req_addr;
`endif

    assign accept         = bus.req_valid && bus.req_ready;
    assign err_n          = (src[1:0] != 2'b00) || (src[31:DEPTH_LOG2+2] != '0);
    assign inst_n         = err_n ? NOP : mem[src[DEPTH_LOG2+1:2]];
    assign bus.req_ready  = (state == IDLE) && !bus.load_en && !rst;
    assign bus.resp_valid = (state == RESP);
    assign busy           = (state != IDLE);

    always_comb begin
        state_n = state;
        cap     = 1'b0;
`ifdef IMEM_WAIT_STATE_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: if (accept) begin
`ifdef IMEM_WAIT_STATE_EN
                if (WAIT_CYCLES > 0) begin
                    state_n = WAIT;
                    cnt_n   = 4'(WAIT_CYCLES - 1);
                end else begin
                    state_n = RESP;
                    cap     = 1'b1;
                end
`else
                state_n = RESP;
                cap     = 1'b1;
`endif
            end
`ifdef IMEM_WAIT_STATE_EN
            WAIT: if (cnt == 4'd0) begin
                state_n = RESP;
                cap     = 1'b1;
            end else begin
                cnt_n = cnt - 4'd1;
            end
`endif
            RESP: if (bus.resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.resp_inst <= '0;
            bus.resp_err  <= 1'b0;
`ifdef IMEM_WAIT_STATE_EN
            cnt           <= '0;
            addr          <= '0;
`endif
        end else begin
            state <= state_n;
            if (cap) begin
                bus.resp_inst <= inst_n;
                bus.resp_err  <= err_n;
            end
`ifdef IMEM_WAIT_STATE_EN
            cnt <= cnt_n;
            if (accept) addr <= bus.req_addr;
`endif
        end
    end

    // Memory survives reset; a same-edge load leaves the captured word at its old value.
    always_ff @(posedge clk) begin
        if (bus.load_en && !rst) mem[bus.load_addr] <= bus.load_data;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in 32-bit words (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per fetch, range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch request from core.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_addr  input  32  byte address of the instruction.
REQ-008 SHALL have port resp_valid  output  1  response data valid.
REQ-009 SHALL have port resp_ready  input  1  core accepts the response.
REQ-010 SHALL have port resp_inst  output  32  fetched instruction word.
REQ-011 SHALL have port resp_err  output  1  request was misaligned or out of range.
REQ-012 SHALL have port load_en  input  1  program-load write strobe.
REQ-013 SHALL have port load_addr  input  DEPTH_LOG2  word address for the load write.
REQ-014 SHALL have port load_data  input  32  word written on load_en.
REQ-015 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 SHALL assert req_ready only in IDLE with load_en=0; load writes take priority over fetch acceptance.
REQ-018 SHALL accept a request when req_valid and req_ready are both 1 in the same cycle; it SHALL latch req_addr and leave IDLE.
REQ-019 SHALL use word index req_addr[DEPTH_LOG2+1:2] for the memory read.
REQ-020 SHALL flag an error when req_addr[1:0]!=0 or req_addr[31:DEPTH_LOG2+2]!=0: resp_err=1, resp_inst=32'h00000013 (NOP), and no memory read.
REQ-021 SHALL, on acceptance, go to WAIT if wait states are enabled and WAIT_CYCLES>0, otherwise go directly to RESP.
REQ-022 SHALL count WAIT_CYCLES cycles in WAIT with a 4-bit down-counter, then enter RESP.
REQ-023 SHALL register resp_inst/resp_err on the transition into RESP; resp_valid SHALL be 1 exactly in RESP.
REQ-024 SHALL hold resp_valid, resp_inst and resp_err stable in RESP until resp_ready=1, then return to IDLE on the next edge.
REQ-025 SHALL NOT accept a new request in the cycle that a response completes (req_ready stays 0 in RESP); back-to-back throughput is therefore one fetch per latency+1 cycles.
REQ-026 SHALL write load_data to mem[load_addr] on any cycle with load_en=1, in any state.
REQ-027 SHALL return the old word when a load write hits the word being captured in the same edge (read-before-write).
REQ-028 SHALL ignore req_valid while not in IDLE; the requester must hold req_valid until it sees req_ready.
REQ-029 SHALL give a latency from the accept edge to resp_valid=1 of 1 cycle without wait states and WAIT_CYCLES+1 cycles with them.

Reset
REQ-030 SHALL, while rst=1, immediately force state=IDLE, counter=0, resp_valid=0, resp_inst=0, resp_err=0 and busy=0; req_ready SHALL be 0 while rst=1.
REQ-031 SHALL discard any in-flight fetch or response when reset is asserted mid-operation, with no response issued after release.
REQ-032 SHALL NOT clear memory contents on reset; loads are ignored while rst=1.

Configuration
REQ-033 SHALL compile in the WAIT state and wait-state counter when macro IMEM_WAIT_STATE_EN is defined, giving latency WAIT_CYCLES+1.
REQ-034 SHALL omit the WAIT state and counter when IMEM_WAIT_STATE_EN is undefined; WAIT_CYCLES SHALL then be ignored and latency SHALL be 1.

Verification
REQ-035 SHALL cover: load mem[4]=32'h00500E13, then request addr 32'h10 with resp_ready=1 -> resp_valid on cycle 1 (macro off) or cycle 3 (macro on, WAIT_CYCLES=2), resp_inst=32'h00500E13, resp_err=0.
REQ-036 SHALL cover: request addr 32'h12 -> resp_err=1, resp_inst=32'h00000013.
REQ-037 SHALL cover: request addr 32'h00001000 (DEPTH_LOG2=10) -> resp_err=1, resp_inst=32'h00000013.
REQ-038 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and resp_inst stay constant; req_ready=0 throughout; IDLE is reached one cycle after resp_ready=1.
REQ-039 SHALL cover: load_en writing mem[4]=32'hFFFFFFFF on the RESP-entry edge of a fetch of addr 32'h10 -> old word returned; a refetch returns 32'hFFFFFFFF.
REQ-040 SHALL cover: rst pulsed during WAIT -> outputs 0 immediately, no resp_valid after release, memory still holds the loaded data.
